count_sequence_checker: RTL and testbench
=========================================

# count_sequence_checker

Monitors the output of the lab's synchronous binary counter and checks that each sampled value is the previous value plus one, modulo 2^WIDTH. It locks onto a clean run of increments, then flags and counts every broken step. It sits beside the counter in the lab designs as the consuming end of its Q bus, and is used both in self-checking benches and on-board.

## Interface
- WIDTH, default 3: width of the monitored count bus.
- LOCK_COUNT, default 2: consecutive correct steps needed to enter LOCKED (legal range 1 to 15).
- ERR_W, default 8: width of the error counter.
- clk, input, 1: single clock, rising-edge.
- clear, input, 1: asynchronous, active-high reset.
- sample_en, input, 1: q_in is valid and is evaluated this cycle.
- q_in, input, WIDTH: counter value under test.
- locked, output, 1: checker has seen LOCK_COUNT consecutive correct steps since the last break.
- err_pulse, output, 1: one-cycle pulse when a step fails while LOCKED.
- err_count, output, ERR_W: number of LOCKED-state failures, saturating.
- expected, output, WIDTH: value the checker will accept on the next sample (last sample + 1).

## Operation
- FSM states: IDLE, ACQUIRE, LOCKED.
- Internal registers:
  - prev (WIDTH): last sampled value.
  - run (4 bits): consecutive good-step count.
- Good step: q_in == prev + 1, computed in WIDTH bits so the all-ones to 0 wrap counts as correct (7 to 0 for WIDTH=3).
- All state changes happen only on cycles with sample_en=1. With sample_en=0, state, prev, run and all outputs hold, and err_pulse is 0.
- IDLE:
  - First sample loads prev = q_in and run = 0.
  - Moves to ACQUIRE. No check is made on this sample.
- ACQUIRE:
  - Good step: run += 1 and prev = q_in. If run+1 == LOCK_COUNT, move to LOCKED and clear run.
  - Bad step: run = 0, prev = q_in, stay in ACQUIRE. No error is flagged while acquiring.
- LOCKED:
  - Good step: prev = q_in, stay in LOCKED.
  - Bad step: err_pulse = 1 for one cycle; err_count += 1, saturating at all-ones; prev = q_in (resync to the new value); run = 0; move to ACQUIRE.
- Output derivation:
  - locked = (state == LOCKED).
  - expected = prev + 1 (WIDTH bits). It holds 0 until the first sample after reset.

## Timing
- All outputs are registered. A sample at edge N is reflected in locked, err_pulse, err_count and expected after edge N.
- Reset values (applied immediately when clear is asserted, asynchronously):
  - state = IDLE, prev = all-ones (so expected = 0), run = 0.
  - locked = 0, err_pulse = 0, err_count = 0.
- clear asserted mid-run discards all history. After release, the first sample is treated as an IDLE capture.
- Minimum lock latency from reset: 1 + LOCK_COUNT valid samples. With LOCK_COUNT=2, locked rises after the 3rd sample.
- With back-to-back sample_en, err_pulse can assert at most every (LOCK_COUNT+1)th sample, because relocking is required first.
- Once err_count reaches all-ones (255 for ERR_W=8), further failures still pulse err_pulse but leave err_count unchanged.

## Configuration
- CHECKER_DIR_EN defined:
  - Adds input port dir (1 bit) after q_in.
  - dir=1 means the good step is prev + 1; dir=0 means the good step is prev − 1, with 0 to all-ones counted as correct.
  - expected follows dir combinationally from prev.
  - A change of dir is not itself an error; only the step value is judged.
- CHECKER_DIR_EN not defined:
  - No dir port; the checker is up-count only, exactly as described above.

## Structure
- Shared package holds:
  - The state enumeration (IDLE, ACQUIRE, LOCKED) and its 2-bit encoding.
  - The default WIDTH/LOCK_COUNT/ERR_W constants, so the counter and the checker agree on bus width.
- One sub-module, sat_counter: parameterised saturating incrementer used for err_count. The FSM and step comparator stay in the top module.

## Test plan
- Counter chain, good sequence:
  - Stimulus: clear=1 for 12 ns, then release; feed 0,1,2,…,7,0,1 with sample_en=1 every cycle.
  - Required: locked=1 after the 3rd sample; wrap 7→0 produces no error; err_count=0 throughout.
- Single skip while locked:
  - Stimulus: after lock, feed 3,4,6,7,0.
  - Required: err_pulse=1 for exactly one cycle after the 6 sample; err_count=1; locked=0, then 1 again after the 0 sample.
- Errors during acquire:
  - Stimulus: from reset, feed 5,2,7,1.
  - Required: locked stays 0, err_pulse never asserts, err_count=0.
- Gated sampling:
  - Stimulus: locked on 2; sample_en=0 for 5 cycles with q_in=6; then sample_en=1 with q_in=3.
  - Required: no change during the gap; the 3 sample is a good step with no error; expected=4.
- Saturation and reset:
  - Stimulus: force 260 locked failures with ERR_W=8, then assert clear mid-sequence.
  - Required: err_count holds at 255 with err_pulse still pulsing; clear immediately gives err_count=0, locked=0, expected=0.
- CHECKER_DIR_EN build:
  - Stimulus: dir=0; feed 2,1,0,7,6.
  - Required: lock is reached, no errors; expected=5 after the 6 sample.

Source files
------------

// File: rtl/count_sequence_checker_pkg.sv
// rtl/count_sequence_checker_pkg.sv - shared state encoding and default bus widths for the counter and its checker
package count_sequence_checker_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  localparam int DEF_WIDTH      = 3;
  localparam int DEF_LOCK_COUNT = 2;
  localparam int DEF_ERR_W      = 8;

endpackage

// File: rtl/count_sequence_checker_if.sv
// rtl/count_sequence_checker_if.sv - count bus between counter (master) and checker (slave); dir exists only with CHECKER_DIR_EN
interface count_sequence_checker_if
  import count_sequence_checker_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ERR_W = DEF_ERR_W
);
  logic             sample_en;
  logic [WIDTH-1:0] q_in;
`ifdef CHECKER_DIR_EN
  logic             dir;
`endif
  logic             locked;
  logic             err_pulse;
  logic [ERR_W-1:0] err_count;
  logic [WIDTH-1:0] expected;

`ifdef CHECKER_DIR_EN
  modport master (output sample_en, q_in, dir, input locked, err_pulse, err_count, expected);
  modport slave  (input sample_en, q_in, dir, output locked, err_pulse, err_count, expected);
`else
  modport master (output sample_en, q_in, input locked, err_pulse, err_count, expected);
  modport slave  (input sample_en, q_in, output locked, err_pulse, err_count, expected);
`endif
endinterface

// File: rtl/count_sequence_checker_sat_counter.sv
// rtl/count_sequence_checker_sat_counter.sv - saturating incrementer holding at all-ones
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);
  localparam logic [W-1:0] ONE = W'(1);

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + ONE;
    end
  end
endmodule

// File: rtl/count_sequence_checker.sv
// rtl/count_sequence_checker.sv - locks onto a +1 (or -1 with CHECKER_DIR_EN) count run and counts broken steps
module count_sequence_checker
  import count_sequence_checker_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int LOCK_COUNT = DEF_LOCK_COUNT,
  parameter int ERR_W      = DEF_ERR_W
) (
  input logic                    clk,
  input logic                    clear,
  count_sequence_checker_if.slave bus
);
  localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);
  localparam logic [3:0]       LOCK_N = 4'(LOCK_COUNT);

  state_t           state;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] step;
  logic [3:0]       run;
  logic [3:0]       run_inc;
  logic             good;
  logic             err_hit;
  logic             err_pulse_r;

  // prev resets to all-ones so step (and expected) reads 0 before the first sample
  always_comb begin
    step = prev + ONE;
`ifdef CHECKER_DIR_EN
    if (!bus.dir) step = prev - ONE;
`endif
  end

  assign run_inc = run + 4'd1;
  assign good    = (bus.q_in == step);
  assign err_hit = bus.sample_en && (state == LOCKED) && !good;

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state       <= IDLE;
      prev        <= '1;
      run         <= '0;
      err_pulse_r <= 1'b0;
    end else begin
      err_pulse_r <= 1'b0;
      if (bus.sample_en) begin
        prev <= bus.q_in;
        case (state)
          IDLE: begin
            run   <= '0;
            state <= ACQUIRE;
          end
          ACQUIRE: begin
            if (!good) begin
              run <= '0;
            end else if (run_inc == LOCK_N) begin
              run   <= '0;
              state <= LOCKED;
            end else begin
              run <= run_inc;
            end
          end
          LOCKED: begin
            if (!good) begin
              err_pulse_r <= 1'b1;
              run         <= '0;
              state       <= ACQUIRE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  sat_counter #(.W(ERR_W)) u_err_count (
    .clk   (clk),
    .clear (clear),
    .inc   (err_hit),
    .count (bus.err_count)
  );

  assign bus.locked    = (state == LOCKED);
  assign bus.err_pulse = err_pulse_r;
  assign bus.expected  = step;
endmodule

// File: tb/tb_count_sequence_checker.sv
// tb/tb_count_sequence_checker.sv - directed bench for count_sequence_checker (WIDTH=3, LOCK_COUNT=2, ERR_W=8)
module tb_count_sequence_checker;
  logic clk;
  logic clear;
  int   errors;
  int   checks;

  count_sequence_checker_if #(.WIDTH(3), .ERR_W(8)) bus ();

  count_sequence_checker #(.WIDTH(3), .LOCK_COUNT(2), .ERR_W(8)) dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic samp(input logic [2:0] v);
    bus.sample_en = 1'b1;
    bus.q_in      = v;
    @(posedge clk);
    #1;
  endtask

  task automatic gap(input logic [2:0] v);
    bus.sample_en = 1'b0;
    bus.q_in      = v;
    @(posedge clk);
    #1;
  endtask

  task automatic outs(input string tag, input logic lk, input logic ep, input int ec, input logic [2:0] ex);
    chk({tag, ".locked"}, 32'(bus.locked), 32'(lk));
    chk({tag, ".err_pulse"}, 32'(bus.err_pulse), 32'(ep));
    chk({tag, ".err_count"}, 32'(bus.err_count), 32'(ec));
    chk({tag, ".expected"}, 32'(bus.expected), 32'(ex));
  endtask

  initial begin
    logic [2:0] p;
    logic [2:0] v;
    int         ec;
    errors        = 0;
    checks        = 0;
    clear         = 1'b1;
    bus.sample_en = 1'b0;
    bus.q_in      = '0;
`ifdef CHECKER_DIR_EN
    bus.dir       = 1'b1;
`endif
    #2;
    outs("reset", 1'b0, 1'b0, 0, 3'd0);
    #10 clear = 1'b0;

    // good sequence 0..7,0,1 with wrap
    for (int i = 0; i < 10; i++) begin
      v = 3'(i);
      samp(v);
      outs($sformatf("good%0d", i), (i >= 2), 1'b0, 0, v + 3'd1);
    end

    // single skip while locked (prev=1)
    samp(3'd2); outs("skip_2", 1'b1, 1'b0, 0, 3'd3);
    samp(3'd3); outs("skip_3", 1'b1, 1'b0, 0, 3'd4);
    samp(3'd4); outs("skip_4", 1'b1, 1'b0, 0, 3'd5);
    samp(3'd6); outs("skip_6", 1'b0, 1'b1, 1, 3'd7);
    samp(3'd7); outs("skip_7", 1'b0, 1'b0, 1, 3'd0);
    samp(3'd0); outs("skip_0", 1'b1, 1'b0, 1, 3'd1);

    // errors during acquire from reset
    clear = 1'b1;
    #1;
    outs("clr1", 1'b0, 1'b0, 0, 3'd0);
    #2 clear = 1'b0;
    samp(3'd5); outs("acq_5", 1'b0, 1'b0, 0, 3'd6);
    samp(3'd2); outs("acq_2", 1'b0, 1'b0, 0, 3'd3);
    samp(3'd7); outs("acq_7", 1'b0, 1'b0, 0, 3'd0);
    samp(3'd1); outs("acq_1", 1'b0, 1'b0, 0, 3'd2);

    // gated sampling: lock on 2, idle with q_in=6, then sample 3
    samp(3'd0);
    samp(3'd1); outs("gate_1", 1'b0, 1'b0, 0, 3'd2);
    samp(3'd2); outs("gate_2", 1'b1, 1'b0, 0, 3'd3);
    for (int i = 0; i < 5; i++) begin
      gap(3'd6);
      outs($sformatf("gap%0d", i), 1'b1, 1'b0, 0, 3'd3);
    end
    samp(3'd3); outs("gate_3", 1'b1, 1'b0, 0, 3'd4);

    // saturation: 260 locked failures, each followed by a relock
    p  = 3'd3;
    ec = 0;
    for (int i = 0; i < 260; i++) begin
      p = p + 3'd2;
      samp(p);
      ec = (ec < 255) ? ec + 1 : 255;
      chk($sformatf("sat%0d.err_pulse", i), 32'(bus.err_pulse), 32'd1);
      chk($sformatf("sat%0d.err_count", i), 32'(bus.err_count), 32'(ec));
      p = p + 3'd1; samp(p);
      p = p + 3'd1; samp(p);
      chk($sformatf("sat%0d.locked", i), 32'(bus.locked), 32'd1);
    end
    p = p + 3'd3;
    samp(p); outs("sat_last", 1'b0, 1'b1, 255, p + 3'd1);

    // clear mid-sequence takes effect before the next edge
    bus.sample_en = 1'b1;
    clear = 1'b1;
    #1;
    outs("clr2", 1'b0, 1'b0, 0, 3'd0);
    @(posedge clk);
    #1;
    outs("clr2_held", 1'b0, 1'b0, 0, 3'd0);
    #2 clear = 1'b0;
    samp(3'd4); outs("post_clr", 1'b0, 1'b0, 0, 3'd5);

`ifdef CHECKER_DIR_EN
    clear = 1'b1;
    #2 clear = 1'b0;
    bus.dir = 1'b0;
    samp(3'd2); outs("dn_2", 1'b0, 1'b0, 0, 3'd1);
    samp(3'd1); outs("dn_1", 1'b0, 1'b0, 0, 3'd0);
    samp(3'd0); outs("dn_0", 1'b1, 1'b0, 0, 3'd7);
    samp(3'd7); outs("dn_7", 1'b1, 1'b0, 0, 3'd6);
    samp(3'd6); outs("dn_6", 1'b1, 1'b0, 0, 3'd5);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
